fetch_unit: RTL

//   Instruction-fetch front end that sits directly upstream of if_id_reg. It owns the fetch PC,

---
 rtl/fetch_unit.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch front end feeding the IF/ID register. It owns the fetch
//   PC and issues word requests to instruction memory over a req/gnt/rvalid
//   handshake. It buffers each returned instruction together with its PC in a
//   DEPTH-entry FIFO and presents the FIFO head over a valid/ready interface.
//   A redirect flushes the FIFO and marks every response still in flight to
//   be dropped when it arrives.
//
// Parameters
//   DEPTH     FIFO entries; also caps in-flight plus buffered fetches
//             (power of 2, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk              rising-edge clock
//   reset            synchronous, active-low reset (0 = reset)
//   redirect_valid   flush and restart fetch at redirect_pc
//   redirect_pc      new fetch address (bits [1:0] ignored)
//   imem_req         fetch request
//   imem_addr        word-aligned fetch address
//   imem_gnt         request accepted this cycle
//   imem_rvalid      response valid; responses return in request order
//   imem_rdata       instruction word
//   out_valid        out_instruction / out_pc valid (FIFO head)
//   out_ready        IF/ID accepts this cycle (low = stall)
//   out_instruction  fetched instruction
//   out_pc           PC of out_instruction
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc
);

  // Counters hold 0..DEPTH inclusive; pointers index 0..DEPTH-1 and wrap
  // naturally because DEPTH is a power of two.
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {
    BOOT,
    FETCH
  } state_t;

  state_t state, state_next;

  logic [31:0]   fetch_pc, fetch_pc_next;
  logic [31:0]   resp_pc, resp_pc_next;
  logic [CW-1:0] inflight, inflight_next;
  logic [CW-1:0] discard, discard_next;
  logic [CW-1:0] fifo_count, fifo_count_next;
  logic [PW-1:0] wr_ptr, wr_ptr_next;
  logic [PW-1:0] rd_ptr, rd_ptr_next;

  logic [31:0] fifo_instr [DEPTH];
  logic [31:0] fifo_pc    [DEPTH];

  logic          grant;
  logic          push;
  logic          pop;
  logic [CW:0]   credit_used;
  logic [31:0]   redirect_base;
  logic [CW-1:0] outstanding;

  // -------------------------------------------------------------------------
  // FSM: BOOT holds the request low for one cycle, then FETCH forever.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of a combinational block gets a default before any
  // branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    case (state)
      BOOT: begin
        state_next = FETCH;
      end
      FETCH: begin
        state_next = FETCH;
        // Credit rule: never have more words owed to us than FIFO slots.
        imem_req   = (credit_used < {1'b0, DEPTH_C});
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------
  always_comb begin
    credit_used   = {1'b0, inflight} + {1'b0, fifo_count};
    imem_addr     = fetch_pc;
    grant         = imem_req && imem_gnt;
    out_valid     = (fifo_count != '0);
    pop           = out_valid && out_ready;
    // A word arriving in the redirect cycle is stale by definition.
    push          = imem_rvalid && (discard == '0) && !redirect_valid;
    redirect_base = redirect_pc & 32'hFFFF_FFFC;
    // Requests still owed a response after this cycle's grant and return.
    outstanding   = inflight + CW'(grant) - CW'(imem_rvalid);
    // Gate the head so the outputs read zero whenever the FIFO is empty,
    // including straight out of reset.
    out_instruction = out_valid ? fifo_instr[rd_ptr] : '0;
    out_pc          = out_valid ? fifo_pc[rd_ptr]    : '0;
  end

  // -------------------------------------------------------------------------
  // Next-state datapath. A redirect overrides every other update.
  // -------------------------------------------------------------------------
  always_comb begin
    fetch_pc_next   = fetch_pc;
    resp_pc_next    = resp_pc;
    inflight_next   = outstanding;
    discard_next    = discard;
    fifo_count_next = fifo_count;
    wr_ptr_next     = wr_ptr;
    rd_ptr_next     = rd_ptr;

    if (redirect_valid) begin
      fetch_pc_next   = redirect_base;
      resp_pc_next    = redirect_base;
      // Everything still owed by memory belongs to the old path.
      discard_next    = outstanding;
      fifo_count_next = '0;
      wr_ptr_next     = '0;
      rd_ptr_next     = '0;
    end else begin
      if (grant) begin
        fetch_pc_next = fetch_pc + 32'd4;
      end
      if (imem_rvalid && (discard != '0)) begin
        discard_next = discard - CW'(1);
      end
      if (push) begin
        resp_pc_next = resp_pc + 32'd4;
        wr_ptr_next  = wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr + PW'(1);
      end
      fifo_count_next = fifo_count + CW'(push) - CW'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc   <= RESET_PC;
      resp_pc    <= RESET_PC;
      inflight   <= '0;
      discard    <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      fetch_pc   <= fetch_pc_next;
      resp_pc    <= resp_pc_next;
      inflight   <= inflight_next;
      discard    <= discard_next;
      fifo_count <= fifo_count_next;
      wr_ptr     <= wr_ptr_next;
      rd_ptr     <= rd_ptr_next;
    end
  end

  // NOTE: the storage array is deliberately not reset; fifo_count defines
  // which entries are live and the outputs are gated while it is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]    <= resp_pc;
    end
  end

  // -------------------------------------------------------------------------
  // Invariants
  // -------------------------------------------------------------------------
  a_inflight_max : assert property (@(posedge clk) disable iff (!reset)
    inflight <= DEPTH_C);

  a_discard_le_inflight : assert property (@(posedge clk) disable iff (!reset)
    discard <= inflight);

  a_no_fifo_overflow : assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && (fifo_count == DEPTH_C)));

  a_no_unrequested_response : assert property (@(posedge clk) disable iff (!reset)
    imem_rvalid |-> (inflight != '0));

endmodule
